// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: parametrised pipelined carry-select adder with per-stage valid/ready backpressure.
// Define CSA_PIPE_OVF_EN to add the registered signed-overflow output o_overflow.
module csa_pipe_adder #(
  parameter int WIDTH  = 46,
  parameter int BLOCK  = 4,
  parameter int STAGES = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
`ifdef CSA_PIPE_OVF_EN
  ,
  output logic             o_overflow
`endif
);
  localparam int NSEG = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int SPS  = (NSEG + STAGES - 1) / STAGES;
  localparam int TOPW = WIDTH - (NSEG - 1) * BLOCK;
  localparam logic [BLOCK-1:0] TOPM = {BLOCK{1'b1}} >> (BLOCK - TOPW);
  if (WIDTH < 2 || BLOCK < 1 || BLOCK > WIDTH || STAGES < 1 || STAGES > NSEG) begin : g_bad_params
    $error("csa_pipe_adder: illegal WIDTH/BLOCK/STAGES combination");
  end
  logic [STAGES-1:0] v, ld, c_r, in_c, in_v, nx_c;
  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  s_r [STAGES];
  logic [WIDTH-1:0]  in_a [STAGES];
  logic [WIDTH-1:0]  in_b [STAGES];
  logic [WIDTH-1:0]  in_s [STAGES];
  logic [WIDTH-1:0]  nx_s [STAGES];
  // A stage is blocked only if it and every stage after it are full and the sink stalls.
  always_comb begin
    logic full;
    ld = '0;
    full = !i_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full = full && v[k];
      ld[k] = !full;
    end
  end
  always_comb begin
    logic c;
    logic [BLOCK-1:0] am, bm, m;
    logic [BLOCK:0] s0, s1, s;
    c = 1'b0;
    am = '0;
    bm = '0;
    m = '0;
    s0 = '0;
    s1 = '0;
    s = '0;
    for (int k = 0; k < STAGES; k++) begin
      in_a[k] = k == 0 ? i_add_term1 : a_r[k == 0 ? 0 : k - 1];
      in_b[k] = k == 0 ? i_add_term2 : b_r[k == 0 ? 0 : k - 1];
      in_s[k] = k == 0 ? '0 : s_r[k == 0 ? 0 : k - 1];
      in_c[k] = k == 0 ? i_cin : c_r[k == 0 ? 0 : k - 1];
      in_v[k] = k == 0 ? i_valid : v[k == 0 ? 0 : k - 1];
      nx_s[k] = in_s[k];
      c = in_c[k];
      for (int j = 0; j < NSEG; j++) begin
        if (j / SPS == k) begin
          m = j == NSEG - 1 ? TOPM : '1;
          am = BLOCK'(in_a[k] >> (j * BLOCK)) & m;
          bm = BLOCK'(in_b[k] >> (j * BLOCK)) & m;
          s0 = {1'b0, am} + {1'b0, bm};
          s1 = s0 + (BLOCK + 1)'(1);
          s = j == 0 ? s0 + (BLOCK + 1)'(c) : (c ? s1 : s0);
          nx_s[k] = (nx_s[k] & ~(WIDTH'(m) << (j * BLOCK))) | (WIDTH'(s[BLOCK-1:0] & m) << (j * BLOCK));
          c = j == NSEG - 1 ? s[TOPW] : s[BLOCK];
        end
      end
      nx_c[k] = c;
    end
  end
  // Data registers only move on real transactions so outputs stay quiet across bubbles.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (i_rst) begin
        v[k] <= 1'b0;
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
      end else begin
        if (ld[k]) v[k] <= in_v[k];
        if (ld[k] && in_v[k]) begin
          a_r[k] <= in_a[k];
          b_r[k] <= in_b[k];
          s_r[k] <= nx_s[k];
          c_r[k] <= nx_c[k];
        end
      end
    end
  end
  assign o_ready = ld[0];
  assign o_valid = v[STAGES-1];
  assign o_sum = s_r[STAGES-1];
  assign o_cout = c_r[STAGES-1];
`ifdef CSA_PIPE_OVF_EN
  assign o_overflow = a_r[STAGES-1][WIDTH-1] ^ b_r[STAGES-1][WIDTH-1] ^ s_r[STAGES-1][WIDTH-1] ^ c_r[STAGES-1];
`endif
endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb_csa_pipe_adder: scoreboard bench for csa_pipe_adder (defaults) plus a 10/4/2 partial-segment instance.
module tb_csa_pipe_adder;
  localparam int W = 46;
  logic clk = 1'b0;
  logic rst = 1'b1, vin = 1'b0, rdy_in = 1'b1, cin = 1'b0;
  logic rdy_out, vout, cout;
  logic [W-1:0] a = '0, b = '0, sum;
  logic [W-1:0] ones = '1;
  logic pv = 1'b0, pcin = 1'b0, pri = 1'b1, pro, pvo, pco;
  logic [9:0] pa = '0, pb = '0, ps;
  int checks = 0, errors = 0;
  logic [W:0] sb [$];
  logic [W:0] exp_v;
`ifdef CSA_PIPE_OVF_EN
  logic ovf;
`endif
  always #5 clk = ~clk;
  csa_pipe_adder dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vin), .o_ready(rdy_out),
    .i_add_term1(a), .i_add_term2(b), .i_cin(cin),
    .o_valid(vout), .i_ready(rdy_in), .o_sum(sum), .o_cout(cout)
`ifdef CSA_PIPE_OVF_EN
    , .o_overflow(ovf)
`endif
  );
  csa_pipe_adder #(.WIDTH(10), .BLOCK(4), .STAGES(2)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_valid(pv), .o_ready(pro),
    .i_add_term1(pa), .i_add_term2(pb), .i_cin(pcin),
    .o_valid(pvo), .i_ready(pri), .o_sum(ps), .o_cout(pco)
`ifdef CSA_PIPE_OVF_EN
    , .o_overflow()
`endif
  );
  // Scoreboard: pop on every output transfer, push on every accepted input.
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (vout && rdy_in) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h, required no output", {cout, sum});
        end else begin
          exp_v = sb.pop_front();
          if ({cout, sum} !== exp_v) begin
            errors++;
            $display("FAIL sb_result: got %h, required %h", {cout, sum}, exp_v);
          end
        end
      end
      if (vin && rdy_out) sb.push_back({1'b0, a} + {1'b0, b} + (W + 1)'(cin));
    end
  end
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (vout !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", vout); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h, required 0", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b, required 0", cout); end
    checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", rdy_out); end
    checks++; if (pvo !== 1'b0) begin errors++; $display("FAIL reset_p_valid: got %b, required 0", pvo); end
  endtask
  task automatic test_carry_chain;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 vin = c < 2; a = ones; b = c == 0 ? '0 : ones; cin = 1'b1;
      @(negedge clk);
      checks++; if (vout !== (c >= 3)) begin errors++; $display("FAIL carry_valid c=%0d: got %b, required %b", c, vout, c >= 3); end
      if (c == 3) begin
        checks++; if ({cout, sum} !== {1'b1, {W{1'b0}}}) begin errors++; $display("FAIL carry_ripple: got %h, required %h", {cout, sum}, {1'b1, {W{1'b0}}}); end
      end
      if (c == 4) begin
        checks++; if ({cout, sum} !== {1'b1, ones}) begin errors++; $display("FAIL carry_all_ones: got %h, required %h", {cout, sum}, {1'b1, ones}); end
      end
    end
  endtask
  task automatic test_throughput;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1 vin = c < 8; a = W'(c); b = W'(3 * c); cin = 1'b0;
      @(negedge clk);
      checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL tput_ready c=%0d: got %b, required 1", c, rdy_out); end
      checks++; if (vout !== (c >= 3 && c <= 10)) begin errors++; $display("FAIL tput_valid c=%0d: got %b, required %b", c, vout, c >= 3 && c <= 10); end
      if (c >= 3 && c <= 10) begin
        checks++; if (sum !== W'(4 * (c - 3))) begin errors++; $display("FAIL tput_sum c=%0d: got %0d, required %0d", c, sum, 4 * (c - 3)); end
      end
    end
  endtask
  task automatic test_backpressure;
    int acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1 vin = 1'b1; rdy_in = 1'b0; a = W'(100 + c); b = W'(7 * c); cin = c[0];
      @(negedge clk);
      if (rdy_out) acc++;
      if (c >= 3) begin
        checks++; if (rdy_out !== 1'b0) begin errors++; $display("FAIL bp_ready c=%0d: got %b, required 0", c, rdy_out); end
        checks++; if ({vout, cout, sum} !== {2'b10, W'(100)}) begin errors++; $display("FAIL bp_hold c=%0d: got %b/%0d, required 1/100", c, vout, sum); end
      end
    end
    checks++; if (acc != 3) begin errors++; $display("FAIL bp_accepted: got %0d, required 3", acc); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 vin = 1'b0; rdy_in = 1'b1;
      @(negedge clk);
    end
    checks++; if (sb.size() != 0 || vout !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0d left, required 0", sb.size()); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 vin = 1'b1; rdy_in = 1'b0; a = W'(200 + c); b = W'(c); cin = 1'b0;
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 vin = 1'b1; rdy_in = 1'b1; a = W'(300 + c); b = W'(c); cin = 1'b1;
      @(negedge clk);
      checks++; if ({rdy_out, vout} !== 2'b11) begin errors++; $display("FAIL bp_full_swap c=%0d: got %b, required 11", c, {rdy_out, vout}); end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 vin = 1'b0;
      @(negedge clk);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_swap_drain: got %0d left, required 0", sb.size()); end
  endtask
  task automatic test_random;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1 vin = 1'($urandom_range(0, 1)); rdy_in = ($urandom % 4) != 0; cin = 1'($urandom);
      a = c % 7 == 0 ? ones : W'({$urandom(), $urandom()});
      b = c % 5 == 0 ? ones : W'({$urandom(), $urandom()});
      @(negedge clk);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1 vin = 1'b0; rdy_in = 1'b1;
      @(negedge clk);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d left, required 0", sb.size()); end
  endtask
  task automatic test_partial;
    logic [10:0] pq [$];
    logic [10:0] pe;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 pv = c < 3; pcin = c != 0;
      pa = c == 0 ? 10'h3FF : 10'h155;
      pb = c == 0 ? 10'h001 : (c == 1 ? 10'h2AA : 10'h0AA);
      @(negedge clk);
      if (pv) begin
        checks++; if (pro !== 1'b1) begin errors++; $display("FAIL part_ready c=%0d: got %b, required 1", c, pro); end
        pq.push_back({1'b0, pa} + {1'b0, pb} + 11'(pcin));
      end
      checks++; if (pvo !== (c >= 2)) begin errors++; $display("FAIL part_valid c=%0d: got %b, required %b", c, pvo, c >= 2); end
      if (pvo && pq.size() != 0) begin
        pe = pq.pop_front();
        checks++; if ({pco, ps} !== pe) begin errors++; $display("FAIL part_sum c=%0d: got %h, required %h", c, {pco, ps}, pe); end
      end
    end
    pv = 1'b0;
  endtask
  task automatic test_reset_mid;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 rst = c == 2; vin = c < 2 || c == 5; rdy_in = 1'b1;
      a = c == 5 ? W'(5) : W'(11 + c); b = c == 5 ? W'(6) : W'(22); cin = c == 5;
      @(negedge clk);
      if (c >= 3) begin
        checks++; if (vout !== (c == 8)) begin errors++; $display("FAIL rstmid_valid c=%0d: got %b, required %b", c, vout, c == 8); end
        checks++; if (sum !== (c >= 8 ? W'(12) : W'(0))) begin errors++; $display("FAIL rstmid_sum c=%0d: got %0d, required %0d", c, sum, c >= 8 ? 12 : 0); end
      end
      if (c == 3) begin
        checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, required 1", rdy_out); end
      end
    end
    vin = 1'b0;
  endtask
`ifdef CSA_PIPE_OVF_EN
  task automatic test_overflow;
    logic [W-1:0] oa [2];
    logic [W:0] r;
    oa[0] = W'(46'h1FFF_FFFF_FFFF);
    oa[1] = ones;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 vin = c < 2; a = oa[c < 2 ? c : 0]; b = W'(1); cin = 1'b0;
      @(negedge clk);
      if (c >= 3) begin
        r = {1'b0, oa[c - 3]} + (W + 1)'(1);
        checks++; if ({ovf, cout} !== {oa[c - 3][W-1] == 1'b0 && r[W-1] == 1'b1, r[W]}) begin
          errors++; $display("FAIL ovf c=%0d: got %b%b, required %b%b", c, ovf, cout, oa[c - 3][W-1] == 1'b0 && r[W-1] == 1'b1, r[W]);
        end
      end
    end
  endtask
`endif
  initial begin
    test_reset();
    test_carry_chain();
    test_throughput();
    test_backpressure();
    test_partial();
    test_random();
    test_reset_mid();
`ifdef CSA_PIPE_OVF_EN
    test_overflow();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
